// File: rtl/regreset_pkg.sv
// regreset_seq shared constants: default width, prescaler width
// and the two reset patterns loaded into the ring.
package regreset_pkg;

  localparam int W_DEF  = 4;
  localparam int NP_DEF = 22;

  localparam logic [W_DEF-1:0] INI0_DEF = 4'b1001;
  localparam logic [W_DEF-1:0] INI1_DEF = 4'b0110;

endpackage

// File: rtl/regreset_seq_prescaler_tick.sv
// prescaler_tick: NP-bit free-running counter with a one-cycle
// terminal-count pulse every 2^NP clocks.
module prescaler_tick
  import regreset_pkg::*;
#(
  parameter int NP = NP_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  logic [NP-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + NP'(1);
    end
  end

  assign tick = (cnt == '1);

endmodule

// File: rtl/regreset_seq.sv
// regreset_seq: two-register ring swapped once per prescaler period.
// Define REGRESET_POR_EN for a self-initialising power-on reset.
module regreset_seq
  import regreset_pkg::*;
#(
  parameter int            NP   = NP_DEF,
  parameter int            W    = W_DEF,
  parameter logic [W-1:0]  INI0 = W'(INI0_DEF),
  parameter logic [W-1:0]  INI1 = W'(INI1_DEF)
) (
  input  logic         clk,
  input  logic         rst,
  output logic [W-1:0] data
);

  logic         rst_i;
  logic         tick;
  logic [W-1:0] reg0;
  logic [W-1:0] reg1;

`ifdef REGRESET_POR_EN
  // Power-up value of the flag forces a reset on the first edge.
  logic por_done = 1'b0;

  always_ff @(posedge clk) begin
    por_done <= 1'b1;
  end

  assign rst_i = rst | ~por_done;
`else
  assign rst_i = rst;
`endif

  prescaler_tick #(
    .NP (NP)
  ) u_pre (
    .clk  (clk),
    .rst  (rst_i),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst_i) begin
      reg0 <= INI0;
      reg1 <= INI1;
    end else if (tick) begin
      reg0 <= reg1;
      reg1 <= reg0;
    end
  end

  assign data = reg0;

endmodule

// File: tb/tb_regreset_seq.sv
// tb_regreset_seq: directed bench for regreset_seq at NP=1 and NP=3
// with a queue of expected data values popped after each edge.
module tb_regreset_seq;

  localparam logic [3:0] P0 = 4'b1001;
  localparam logic [3:0] P1 = 4'b0110;

  logic       clk = 1'b0;
  logic       rst1;
  logic       rst3;
  logic       rstp;
  logic [3:0] data1;
  logic [3:0] data3;
  logic [3:0] datap;

  logic [3:0] q1[$];
  logic [3:0] q3[$];

  int total;
  int passed;
  int ticks;

  always #1 clk = ~clk;

  regreset_seq #(.NP(1), .W(4)) d1 (
    .clk  (clk),
    .rst  (rst1),
    .data (data1)
  );

  regreset_seq #(.NP(3), .W(4)) d3 (
    .clk  (clk),
    .rst  (rst3),
    .data (data3)
  );

  regreset_seq #(.NP(1), .W(4)) dp (
    .clk  (clk),
    .rst  (rstp),
    .data (datap)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Drive resets, queue expectations, take one edge, compare.
  task automatic step(input logic r1, input logic r3,
                      input logic [3:0] e1, input logic [3:0] e3);
    rst1 = r1;
    rst3 = r3;
    q1.push_back(e1);
    q3.push_back(e3);
    @(posedge clk);
    @(negedge clk);
    chk("data_np1", {28'd0, data1}, {28'd0, q1.pop_front()});
    chk("data_np3", {28'd0, data3}, {28'd0, q3.pop_front()});
  endtask

  function automatic logic [3:0] pat(input int k, input int np);
    return ((k >> np) & 1) != 0 ? P1 : P0;
  endfunction

  initial begin
    total  = 0;
    passed = 0;
    ticks  = 0;
    rst1   = 1'b1;
    rst3   = 1'b1;
    rstp   = 1'b0;

    step(1'b1, 1'b1, P0, P0);
    chk("reset_reg1", {28'd0, d1.reg1}, {28'd0, P1});
    chk("reset_cnt", {31'd0, d1.u_pre.cnt}, 32'd0);
    chk("reset_reg1_np3", {28'd0, d3.reg1}, {28'd0, P1});
`ifdef REGRESET_POR_EN
    chk("por_edge1", {28'd0, datap}, {28'd0, P0});
`endif

    for (int k = 1; k <= 24; k++) begin
      step(1'b0, 1'b0, pat(k, 1), pat(k, 3));
      chk("cnt_np1", {31'd0, d1.u_pre.cnt}, k % 2);
      chk("tick_np3", {31'd0, d3.u_pre.tick},
          ((k % 8) == 7) ? 32'd1 : 32'd0);
      if (d3.u_pre.tick === 1'b1) ticks++;
`ifdef REGRESET_POR_EN
      if (k == 1) chk("por_edge2", {28'd0, datap}, {28'd0, P0});
      if (k == 2) chk("por_edge3", {28'd0, datap}, {28'd0, P1});
`endif
    end
    chk("tick_count_np3", ticks, 3);

    step(1'b0, 1'b1, pat(25, 1), P0);
    step(1'b0, 1'b1, pat(26, 1), P0);
    chk("pre_midreset", {28'd0, data1}, {28'd0, P1});

    step(1'b1, 1'b1, P0, P0);
    chk("midreset_reg1", {28'd0, d1.reg1}, {28'd0, P1});
    step(1'b0, 1'b1, P0, P0);
    chk("tick_before_rst", {31'd0, d1.u_pre.tick}, 32'd1);

    step(1'b1, 1'b1, P0, P0);
    chk("rst_tick_cnt", {31'd0, d1.u_pre.cnt}, 32'd0);
    chk("rst_tick_reg1", {28'd0, d1.reg1}, {28'd0, P1});

    for (int k = 1; k <= 6; k++) begin
      step(1'b0, 1'b1, pat(k, 1), P0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/regreset_seq.md
# regreset_seq

Two-register circular sequencer with synchronous reset. Two W-bit registers are loaded with constant patterns on reset, then swap contents once per prescaler period, so `data` alternates between the two patterns at a visible rate. It is a self-contained demo and test block for driving LEDs directly from the board clock.

## Interface

Parameters:

- `NP`, default 22: prescaler width in bits; the registers swap every 2^NP clocks. Legal range 1..32. Simulation uses 1.
- `W`, default 4: width of each register and of `data`.
- `INI0`, default 4'b1001: reset value of register 0. It is also the value of `data` after reset.
- `INI1`, default 4'b0110: reset value of register 1.

Ports:

- `clk`, input, 1 bit: the single clock. All state changes on its rising edge.
- `rst`, input, 1 bit: reset, synchronous and active-high. Tie it to 0 when unused.
- `data`, output, W bits: contents of register 0, driven directly from a flop.

## Operation

- State consists of `reg0[W-1:0]`, `reg1[W-1:0]` and an NP-bit free-running counter `cnt`.
- Reset (internal reset high at a rising edge):
  - `reg0` ← INI0, `reg1` ← INI1, `cnt` ← 0.
  - `data` = INI0 after the edge.
- Prescaler:
  - `cnt` increments every clock and wraps from 2^NP−1 to 0.
  - `tick` = (`cnt` == 2^NP−1). It is combinational and high for exactly 1 cycle in every 2^NP.
- Swap on a rising edge with `tick` = 1: `reg0` ← `reg1` and `reg1` ← `reg0` at the same time (a 2-stage ring).
- With `tick` = 0 the registers hold.
- `data` = `reg0`, with no combinational path from inputs.
- Width rules: INI0 and INI1 are truncated or zero-extended to W bits.
- INI0 == INI1 is legal; `data` is then constant.
- Reset has priority over `tick` when both are active at the same edge.
- Reset asserted mid-period discards the partial count. The next swap occurs a full 2^NP cycles after reset is released.

## Timing

- Reset-to-output latency: 1 clock. `data` = INI0 after the first edge that samples reset high.
- After reset is released, `cnt` counts 0,1,…; the first swap takes effect at edge number 2^NP after release.
- `data` then toggles between INI0 and INI1 every 2^NP clocks, with no jitter.
- For NP=1: `data` changes every 2 clocks, giving a period of 4 clocks.

## Configuration

- Macro `REGRESET_POR_EN`:
  - Defined: adds a 1-bit power-on flag `por_done` with initial value 0, which is set to 1 at the first rising edge. Internal reset = `rst` | ~`por_done`. The block therefore self-initializes on the first clock with `rst` tied 0, and `data` = INI0 after edge 1.
  - Not defined: internal reset = `rst` only, and state is undefined until `rst` is pulsed.

## Structure

- Shared package `regreset_pkg`:
  - default width constant (4)
  - default patterns INI0 = 4'b1001, INI1 = 4'b0110
  - default NP = 22
- One sub-module, `prescaler_tick`:
  - parameters: NP
  - ports: `clk`, `rst`, `tick`
  - contains the NP-bit counter and the terminal-count decode.
- The top level holds the two registers, the swap logic and the optional POR flag.

## Test plan

All cases use NP=1, W=4, defaults INI0=1001 and INI1=0110, and a clock of period 2.

- Reset: `rst`=1 for 1 edge → `data`=1001; `reg1`=0110.
- Run after reset release → `data` sequence per edge: 1001, 0110 (edge 2), 0110, 1001 (edge 4), …, toggling every 2 clocks for 20 clocks.
- Reset mid-operation: assert `rst` while `data`=0110 → `data`=1001 next edge; first swap 2 clocks after release.
- Reset and tick at the same edge → `data`=1001 (reset wins), and `cnt`=0.
- NP=3 → `data` holds 8 clocks between changes; `tick` is high 1 cycle in 8.
- With `REGRESET_POR_EN` and `rst` held 0 from time 0 → `data`=1001 after edge 1, 0110 after edge 3.
